// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 16,
  parameter  int NRD      = 2,
  parameter  int NWR      = 1,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW-1:0]    w_ra;
  logic [XLEN-1:0]  w_rd;
  logic             w_hit;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Ports are visited in ascending order so the highest-index enabled port
  // lands last and wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en[w] && !is_zero(wr_addr[w*AW +: AW]))
          r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Clears first, then the issue set, so a same-register set overrides a clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en[w]) w_busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (iss_valid) w_busy_nxt[iss_rd] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    w_ra    = '0;
    w_rd    = '0;
    w_hit   = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      w_ra  = rs_addr[i*AW +: AW];
      w_rd  = r_regs[w_ra];
      w_hit = 1'b0;
      if (BYPASS != 0) begin
        for (int unsigned w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == w_ra)) begin
            w_hit = 1'b1;
            w_rd  = wr_data[w*XLEN +: XLEN];
          end
        end
      end
      if (is_zero(w_ra)) w_rd = '0;
      // Outputs are held at zero for the whole reset interval, bypass included.
      if (!rst) begin
        rs_data[i*XLEN +: XLEN] = w_rd;
        rs_busy[i]              = r_busy[w_ra] & ~w_hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register files (bypass / no bypass) share stimulus and
// are checked against one behavioural model of the architectural state.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NRD*XLEN-1:0] rs_data_b, rs_data_n;
  logic [NRD-1:0]      rs_busy_b, rs_busy_n;
  logic [NREGS-1:0]    busy_vec_b, busy_vec_n;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
               .BYPASS(1), .ZERO_REG(1)) u_byp (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b),
    .rs_busy(rs_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec_b));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
               .BYPASS(0), .ZERO_REG(1)) u_nob (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_n),
    .rs_busy(rs_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec_n));

  typedef struct {
    int          id;
    logic [63:0] data_b;
    logic [63:0] data_n;
    logic [1:0]  busy_b;
    logic [1:0]  busy_n;
    logic [15:0] bv;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_regs [16];
  logic [15:0] m_busy;
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_cyc    = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, id, act, exp);
    end
  endtask

  // Model: x0 reads zero; the newest in-flight write (highest enabled port)
  // is what a bypassed read sees; a busy register becomes not-busy the moment
  // its producer writes back.
  task automatic drive(input bit r, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input bit iss, input logic [3:0] rd);
    exp_t        e;
    logic [3:0]  ra [2];
    logic [3:0]  wa [2];
    logic [31:0] wd [2];
    logic [31:0] committed, newest;
    int          winner;
    @(negedge clk);
    rst = r; rs_addr = {a1, a0}; wr_en = we; wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0}; iss_valid = iss; iss_rd = rd;
    ra[0] = a0; ra[1] = a1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    e.id = n_cyc++;
    e.data_b = '0; e.data_n = '0; e.busy_b = '0; e.busy_n = '0; e.bv = '0;
    if (!r) begin
      e.bv = m_busy;
      for (int p = 0; p < 2; p++) begin
        committed = (ra[p] == 4'd0) ? 32'd0 : m_regs[ra[p]];
        winner = -1;
        for (int w = 1; w >= 0; w--) begin
          if (we[w] && wa[w] == ra[p]) begin winner = w; break; end
        end
        newest = (winner >= 0 && ra[p] != 4'd0) ? wd[winner] : committed;
        e.data_b[p*32 +: 32] = newest;
        e.data_n[p*32 +: 32] = committed;
        e.busy_b[p] = (winner >= 0) ? 1'b0 : m_busy[ra[p]];
        e.busy_n[p] = m_busy[ra[p]];
      end
    end
    q.push_back(e);
    if (r) begin
      for (int k = 0; k < 16; k++) m_regs[k] = '0;
      m_busy = '0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (we[w]) begin
          if (wa[w] != 4'd0) m_regs[wa[w]] = wd[w];
          m_busy[wa[w]] = 1'b0;
        end
      end
      if (iss && rd != 4'd0) m_busy[rd] = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs_data_byp",  e.id, {32'd0, rs_data_b}, {32'd0, e.data_b});
        chk("rs_data_nob",  e.id, {32'd0, rs_data_n}, {32'd0, e.data_n});
        chk("rs_busy_byp",  e.id, {62'd0, rs_busy_b}, {62'd0, e.busy_b});
        chk("rs_busy_nob",  e.id, {62'd0, rs_busy_n}, {62'd0, e.busy_n});
        chk("busy_vec_byp", e.id, {48'd0, busy_vec_b}, {48'd0, e.bv});
        chk("busy_vec_nob", e.id, {48'd0, busy_vec_n}, {48'd0, e.bv});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin : stim
    logic [3:0] w0, w1;
    rst = 1'b1; rs_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_busy = '0;

    drive(1, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);
    for (int r = 0; r < 16; r++)
      drive(0, 4'(r), 4'(15 - r), 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);

    drive(0, 4'd0, 4'd0, 2'b01, 4'd5, 4'd0, 32'hDEADBEEF, 32'd0, 0, 4'd0);
    drive(0, 4'd5, 4'd0, 2'b01, 4'd0, 4'd0, 32'h00001234, 32'd0, 0, 4'd0);
    drive(0, 4'd0, 4'd5, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);
    drive(0, 4'd7, 4'd7, 2'b01, 4'd7, 4'd0, 32'hA5A5A5A5, 32'd0, 0, 4'd0);
    drive(0, 4'd3, 4'd7, 2'b11, 4'd3, 4'd3, 32'h11, 32'h22, 0, 4'd0);
    drive(0, 4'd3, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);

    drive(0, 4'd9, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1, 4'd9);
    drive(0, 4'd9, 4'd0, 2'b01, 4'd9, 4'd0, 32'h99, 32'd0, 1, 4'd9);
    drive(0, 4'd9, 4'd9, 2'b01, 4'd9, 4'd0, 32'h100, 32'd0, 0, 4'd0);
    drive(0, 4'd9, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);
    drive(0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1, 4'd0);
    drive(0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);

    drive(0, 4'd4, 4'd0, 2'b01, 4'd4, 4'd0, 32'h55, 32'd0, 1, 4'd4);
    drive(0, 4'd4, 4'd3, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);
    drive(1, 4'd4, 4'd3, 2'b01, 4'd4, 4'd0, 32'h77, 32'd0, 1, 4'd5);
    drive(1, 4'd4, 4'd5, 2'b11, 4'd4, 4'd5, 32'h1, 32'h2, 1, 4'd4);
    drive(0, 4'd4, 4'd3, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);

    for (int n = 0; n < 400; n++) begin
      w0 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      w1 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      drive($urandom_range(0, 99) == 0, 4'($urandom), 4'($urandom_range(0, 3)),
            2'($urandom), w0, w1, $urandom, $urandom,
            $urandom_range(0, 2) == 0, 4'($urandom));
    end
    drive(0, 4'd1, 4'd2, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);

    @(negedge clk);
    #5;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
